// File: rtl/ysyx_25060170_ifu_if.sv
// ysyx_25060170_ifu_if: fetch-unit bus bundle (imem request/response, IDU hand-off, EXU redirect).
// master = IFU side, slave = environment side (imem + IDU + EXU).
interface ysyx_25060170_ifu_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_fault,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
               inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_fault,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
               inst_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ysyx_25060170_ifu.sv
// ysyx_25060170_ifu: multi-cycle instruction fetch unit, one outstanding imem request.
// Optional build macro IFU_PERF_EN adds perf_fetch_cnt / perf_flush_cnt outputs.
module ysyx_25060170_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    ysyx_25060170_ifu_if.master bus
`ifdef IFU_PERF_EN
    ,
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_flush_cnt
`endif
);
    localparam int unsigned XLEN = 32;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_HALT = 3'd4;

    logic [2:0]      state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [XLEN-1:0] inflight_pc, inflight_pc_nxt;
    logic [XLEN-1:0] inst_q, inst_nxt;
    logic [XLEN-1:0] inst_pc_q, inst_pc_nxt;
    logic            kill, kill_nxt;
    logic            fault_q, fault_nxt;
    logic            redirect_bad_c;
    logic            fetch_fire_c;

    // A misaligned redirect target is a fault; it is never issued to imem.
    assign redirect_bad_c = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    // IDU hand-off; a same-cycle redirect masks inst_valid so no handshake occurs.
    assign fetch_fire_c   = (state == S_HOLD) && !bus.redirect_valid && bus.inst_ready;

    assign bus.imem_req_valid = (state == S_REQ);
    assign bus.imem_req_addr  = pc;
    assign bus.inst_valid     = (state == S_HOLD) && !bus.redirect_valid;
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = inst_pc_q;
    assign bus.fetch_fault    = fault_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            inflight_pc <= '0;
            inst_q      <= '0;
            inst_pc_q   <= '0;
            kill        <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            inflight_pc <= inflight_pc_nxt;
            inst_q      <= inst_nxt;
            inst_pc_q   <= inst_pc_nxt;
            kill        <= kill_nxt;
            fault_q     <= fault_nxt;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        inflight_pc_nxt = inflight_pc;
        inst_nxt        = inst_q;
        inst_pc_nxt     = inst_pc_q;
        kill_nxt        = kill;
        fault_nxt       = fault_q;

        if (redirect_bad_c && (state != S_HALT)) begin
            fault_nxt = 1'b1;
            state_nxt = S_HALT;
        end else begin
            case (state)
                S_IDLE: state_nxt = S_REQ;
                S_REQ: begin
                    if (bus.imem_req_ready) begin
                        inflight_pc_nxt = pc;
                        kill_nxt        = bus.redirect_valid;
                        state_nxt       = S_WAIT;
                    end
                    if (bus.redirect_valid) begin
                        pc_nxt = bus.redirect_pc;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        if (kill || bus.redirect_valid) begin
                            kill_nxt  = 1'b0;
                            state_nxt = S_REQ;
                            if (bus.redirect_valid) begin
                                pc_nxt = bus.redirect_pc;
                            end
                        end else if (bus.imem_rsp_err) begin
                            fault_nxt = 1'b1;
                            state_nxt = S_HALT;
                        end else begin
                            inst_nxt    = bus.imem_rsp_data;
                            inst_pc_nxt = inflight_pc;
                            state_nxt   = S_HOLD;
                        end
                    end else if (bus.redirect_valid) begin
                        pc_nxt   = bus.redirect_pc;
                        kill_nxt = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (bus.redirect_valid) begin
                        pc_nxt    = bus.redirect_pc;
                        state_nxt = S_REQ;
                    end else if (fetch_fire_c) begin
                        pc_nxt    = pc + XLEN'(4);
                        state_nxt = S_REQ;
                    end
                end
                S_HALT:  state_nxt = S_HALT;
                default: state_nxt = S_HALT;
            endcase
        end
    end

`ifdef IFU_PERF_EN
    logic flush_c;
    assign flush_c = bus.redirect_valid && !redirect_bad_c &&
                     ((state == S_REQ) || (state == S_WAIT) || (state == S_HOLD));

    // Free-running performance counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (fetch_fire_c) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (flush_c)      perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif
endmodule
